// File: rtl/fetch_stage_if.sv
// Handshake bundle between the fetch stage, the instruction memory port,
// the redirect source and the downstream IF/ID register.
interface fetch_stage_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] inst_out;
  logic        exc_out;
  logic        allow_in;

  modport master (
    input  redirect_valid, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, allow_in,
    output inst_req, inst_addr, valid_out, pc_out, inst_out, exc_out
  );

  modport slave (
    output redirect_valid, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, allow_in,
    input  inst_req, inst_addr, valid_out, pc_out, inst_out, exc_out
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, keeps several requests in flight,
// drops responses made stale by redirects and buffers {pc, inst, exc} entries.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h1C000000,
  parameter int          OUTSTANDING = 2,
  parameter int          BUF_DEPTH   = 2
) (
  input  logic          aclk,
  input  logic          areset,
  fetch_stage_if.master bus
);

  localparam int CW  = $clog2(OUTSTANDING) + 1;
  localparam int BW  = $clog2(BUF_DEPTH) + 1;
  localparam int QPW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int BPW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int SW  = CW + BW;
  localparam logic [CW-1:0] OUT_MAX   = CW'(OUTSTANDING);
  localparam logic [BW-1:0] BUF_MAX   = BW'(BUF_DEPTH);
  localparam logic [SW-1:0] BUF_MAX_S = SW'(BUF_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } entry_t;

  logic [31:0]    r_pc;
  logic [CW-1:0]  r_inflight;
  logic [CW-1:0]  r_discard;
  logic           r_halted;
  logic [31:0]    r_pcQueue [OUTSTANDING];
  logic [QPW-1:0] r_qHead;
  logic [QPW-1:0] r_qTail;
  entry_t         r_buf [BUF_DEPTH];
  logic [BPW-1:0] r_bufHead;
  logic [BPW-1:0] r_bufTail;
  logic [BW-1:0]  r_bufCount;

  logic [SW-1:0]  w_live;
  logic           w_credit;
  logic           w_req;
  logic           w_accept;
  logic           w_resp;
  logic           w_bufFull;
  logic           w_misalign;
  logic           w_pushResp;
  logic           w_push;
  logic           w_pop;
  logic           w_valid;
  entry_t         w_pushEntry;
  entry_t         w_head;

  function automatic logic [QPW-1:0] qNext(input logic [QPW-1:0] p);
    return (p == QPW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [BPW-1:0] bNext(input logic [BPW-1:0] p);
    return (p == BPW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Live (non-discarded) requests plus buffered entries never exceed the buffer,
  // so every response that is kept is guaranteed a slot.
  assign w_live     = SW'(r_inflight) - SW'(r_discard);
  assign w_credit   = (r_inflight < OUT_MAX) && ((w_live + SW'(r_bufCount)) < BUF_MAX_S);
  assign w_req      = !areset && !bus.redirect_valid && !r_halted &&
                      (r_pc[1:0] == 2'b00) && w_credit;
  assign w_accept   = w_req && bus.inst_addr_ok;
  assign w_resp     = bus.inst_data_ok && (r_inflight != '0);
  assign w_bufFull  = (r_bufCount == BUF_MAX);
  assign w_misalign = (r_pc[1:0] != 2'b00) && !r_halted && (r_inflight == r_discard) &&
                      !w_bufFull && !bus.redirect_valid;
  assign w_pushResp = w_resp && (r_discard == '0) && !bus.redirect_valid;
  assign w_push     = w_pushResp || w_misalign;
  assign w_valid    = (r_bufCount != '0);
  assign w_pop      = w_valid && bus.allow_in;
  assign w_head     = r_buf[r_bufHead];

  always_comb begin
    w_pushEntry = entry_t'{pc: r_pcQueue[r_qHead], inst: bus.inst_rdata, exc: 1'b0};
    if (w_misalign) begin
      w_pushEntry = entry_t'{pc: r_pc, inst: 32'h0, exc: 1'b1};
    end
  end

  assign bus.inst_req  = w_req;
  assign bus.inst_addr = r_pc;
  assign bus.valid_out = w_valid;
  assign bus.pc_out    = w_valid ? w_head.pc   : 32'h0;
  assign bus.inst_out  = w_valid ? w_head.inst : 32'h0;
  assign bus.exc_out   = w_valid && w_head.exc;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_pc       <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
      r_halted   <= 1'b0;
      r_qHead    <= '0;
      r_qTail    <= '0;
      r_bufHead  <= '0;
      r_bufTail  <= '0;
      r_bufCount <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_accept) - CW'(w_resp);
      if (w_accept) r_qTail <= qNext(r_qTail);
      if (w_resp)   r_qHead <= qNext(r_qHead);

      // A redirect marks everything still outstanding after this cycle as stale.
      if (bus.redirect_valid) begin
        r_pc       <= bus.redirect_pc;
        r_discard  <= r_inflight - CW'(w_resp);
        r_halted   <= 1'b0;
        r_bufHead  <= '0;
        r_bufTail  <= '0;
        r_bufCount <= '0;
      end else begin
        if (w_accept) r_pc <= r_pc + 32'd4;
        if (w_resp && (r_discard != '0)) r_discard <= r_discard - 1'b1;
        if (w_misalign) r_halted <= 1'b1;
        if (w_push) r_bufTail <= bNext(r_bufTail);
        if (w_pop)  r_bufHead <= bNext(r_bufHead);
        r_bufCount <= r_bufCount + BW'(w_push) - BW'(w_pop);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (w_accept) r_pcQueue[r_qTail] <= r_pc;
    if (w_push)   r_buf[r_bufTail]   <= w_pushEntry;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a hand-derived vector table, directed corner sequences
// and a long randomized run against a queue-based reference model.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC    = 32'h1C000000;
  localparam int          OUTSTANDING = 2;
  localparam int          BUF_DEPTH   = 2;
  localparam logic [31:0] B           = RESET_PC;

  logic aclk;
  logic areset;
  fetch_stage_if bus();

  fetch_stage #(
    .RESET_PC(RESET_PC),
    .OUTSTANDING(OUTSTANDING),
    .BUF_DEPTH(BUF_DEPTH)
  ) dut (
    .aclk(aclk),
    .areset(areset),
    .bus(bus)
  );

  int nChecks = 0;
  int nFails  = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        stale;
  } infl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        exc;
  } ent_t;

  typedef struct packed {
    logic        redir;
    logic [31:0] rpc;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        allow;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] ePc;
    logic [31:0] eInst;
    logic        eExc;
  } vec_t;

  infl_t       mInfl[$];
  ent_t        mBuf[$];
  logic [31:0] mPc;
  bit          mHalted;
  vec_t        vecs[16];

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  task automatic applyStimulus(input bit rst, input bit redir, input logic [31:0] rpc,
                               input bit aok, input bit dok, input logic [31:0] rd,
                               input bit allow);
    areset             = rst;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.inst_addr_ok   = aok;
    bus.inst_data_ok   = dok;
    bus.inst_rdata     = rd;
    bus.allow_in       = allow;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mInfl.delete();
    mBuf.delete();
    mPc     = RESET_PC;
    mHalted = 1'b0;
  endtask

  function automatic int liveCount();
    int n = 0;
    foreach (mInfl[i]) if (!mInfl[i].stale) n++;
    return n;
  endfunction

  task automatic doReset();
    applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 0);
    repeat (2) @(posedge aclk);
    #1;
    areset = 1'b0;
    modelReset();
  endtask

  // One clock: drive, compare against the model's view of the current cycle, advance the model.
  task automatic runCycle(input bit rst, input bit redir, input logic [31:0] rpc,
                          input bit aok, input bit dok, input logic [31:0] rd,
                          input bit allow, input string tag);
    bit          expReq, expValid, expExc, resp, accept, misalign, pop;
    logic [31:0] expPc, expInst;
    infl_t       f;
    applyStimulus(rst, redir, rpc, aok, dok, rd, allow);
    #2;
    expReq   = !rst && !redir && !mHalted && (mPc[1:0] == 2'b00) &&
               (mInfl.size() < OUTSTANDING) && (liveCount() + mBuf.size() < BUF_DEPTH);
    expValid = mBuf.size() > 0;
    expPc    = expValid ? mBuf[0].pc   : 32'h0;
    expInst  = expValid ? mBuf[0].inst : 32'h0;
    expExc   = expValid && mBuf[0].exc;
    checkOutput({tag, "_req"},   32'(bus.inst_req),  32'(expReq));
    checkOutput({tag, "_addr"},  bus.inst_addr,      mPc);
    checkOutput({tag, "_valid"}, 32'(bus.valid_out), 32'(expValid));
    checkOutput({tag, "_pc"},    bus.pc_out,         expPc);
    checkOutput({tag, "_inst"},  bus.inst_out,       expInst);
    checkOutput({tag, "_exc"},   32'(bus.exc_out),   32'(expExc));
    if (rst) begin
      modelReset();
    end else begin
      resp     = dok && (mInfl.size() > 0);
      accept   = expReq && aok;
      misalign = (mPc[1:0] != 2'b00) && !mHalted && (liveCount() == 0) &&
                 (mBuf.size() < BUF_DEPTH) && !redir;
      pop      = expValid && allow;
      if (pop) void'(mBuf.pop_front());
      if (resp) begin
        f = mInfl.pop_front();
        if (!f.stale && !redir) mBuf.push_back(ent_t'{pc: f.pc, inst: rd, exc: 1'b0});
      end
      if (redir) begin
        mBuf.delete();
        foreach (mInfl[i]) mInfl[i].stale = 1'b1;
        mPc     = rpc;
        mHalted = 1'b0;
      end else begin
        if (accept) begin
          mInfl.push_back(infl_t'{pc: mPc, stale: 1'b0});
          mPc = mPc + 32'd4;
        end
        if (misalign) begin
          mBuf.push_back(ent_t'{pc: mPc, inst: 32'h0, exc: 1'b1});
          mHalted = 1'b1;
        end
      end
    end
    @(posedge aclk);
    #1;
  endtask

  initial begin
    bit          seen;
    bit          rst, redir, aok, dok, allow;
    logic [31:0] rpc;

    //          redir rpc        aok dok rdata         allow | req addr     valid pc        inst          exc
    vecs[0]  = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h0,         1'b1, 1'b1, B,         1'b0, 32'h0,     32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h0,     1'b1, 1'b1, 32'hAAAA0000,  1'b1, 1'b1, B+32'h4,   1'b0, 32'h0,     32'h0,        1'b0};
    vecs[2]  = '{1'b0, 32'h0,     1'b1, 1'b1, 32'hAAAA0004,  1'b1, 1'b0, B+32'h8,   1'b1, B,         32'hAAAA0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h0,         1'b0, 1'b1, B+32'h8,   1'b1, B+32'h4,   32'hAAAA0004, 1'b0};
    vecs[4]  = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h0,         1'b0, 1'b0, B+32'hC,   1'b1, B+32'h4,   32'hAAAA0004, 1'b0};
    vecs[5]  = '{1'b1, B+32'h100, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, B+32'hC,   1'b1, B+32'h4,   32'hAAAA0004, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h0,         1'b1, 1'b1, B+32'h100, 1'b0, 32'h0,     32'h0,        1'b0};
    vecs[7]  = '{1'b0, 32'h0,     1'b0, 1'b1, 32'hDEAD0008,  1'b1, 1'b0, B+32'h104, 1'b0, 32'h0,     32'h0,        1'b0};
    vecs[8]  = '{1'b0, 32'h0,     1'b0, 1'b1, 32'hBBBB0100,  1'b0, 1'b1, B+32'h104, 1'b0, 32'h0,     32'h0,        1'b0};
    vecs[9]  = '{1'b1, B+32'h102, 1'b1, 1'b0, 32'h0,         1'b0, 1'b0, B+32'h104, 1'b1, B+32'h100, 32'hBBBB0100, 1'b0};
    vecs[10] = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h0,         1'b0, 1'b0, B+32'h102, 1'b0, 32'h0,     32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h0,         1'b0, 1'b0, B+32'h102, 1'b1, B+32'h102, 32'h0,        1'b1};
    vecs[12] = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h0,         1'b1, 1'b0, B+32'h102, 1'b1, B+32'h102, 32'h0,        1'b1};
    vecs[13] = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h0,         1'b1, 1'b0, B+32'h102, 1'b0, 32'h0,     32'h0,        1'b0};
    vecs[14] = '{1'b1, B+32'h200, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, B+32'h102, 1'b0, 32'h0,     32'h0,        1'b0};
    vecs[15] = '{1'b0, 32'h0,     1'b1, 1'b0, 32'h0,         1'b1, 1'b1, B+32'h200, 1'b0, 32'h0,     32'h0,        1'b0};

    doReset();
    checkOutput("reset_valid", 32'(bus.valid_out), 32'h0);
    checkOutput("reset_pc",    bus.pc_out,         32'h0);
    checkOutput("reset_inst",  bus.inst_out,       32'h0);
    checkOutput("reset_exc",   32'(bus.exc_out),   32'h0);
    checkOutput("reset_addr",  bus.inst_addr,      RESET_PC);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(0, vecs[i].redir, vecs[i].rpc, vecs[i].aok, vecs[i].dok,
                    vecs[i].rdata, vecs[i].allow);
      #2;
      checkOutput($sformatf("vec%0d_req", i),   32'(bus.inst_req),  32'(vecs[i].eReq));
      checkOutput($sformatf("vec%0d_addr", i),  bus.inst_addr,      vecs[i].eAddr);
      checkOutput($sformatf("vec%0d_valid", i), 32'(bus.valid_out), 32'(vecs[i].eValid));
      checkOutput($sformatf("vec%0d_pc", i),    bus.pc_out,         vecs[i].ePc);
      checkOutput($sformatf("vec%0d_inst", i),  bus.inst_out,       vecs[i].eInst);
      checkOutput($sformatf("vec%0d_exc", i),   32'(bus.exc_out),   32'(vecs[i].eExc));
      @(posedge aclk);
      #1;
    end

    // Redirect lands together with a response: both in-flight fetches are lost.
    doReset();
    runCycle(0, 0, 32'h0,        1, 0, 32'h0,        0, "seqA");
    runCycle(0, 0, 32'h0,        1, 1, 32'h11110000, 0, "seqA");
    runCycle(0, 1, 32'h1C000300, 1, 1, 32'h22220004, 0, "seqA");
    checkOutput("seqA_flushed", 32'(bus.valid_out), 32'h0);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      runCycle(0, 0, 32'h0, 1, 1, $urandom, 1, "seqA");
      if (bus.valid_out) begin
        seen = 1'b1;
        checkOutput("seqA_first_pc", bus.pc_out, 32'h1C000300);
      end
    end
    if (!seen) checkOutput("seqA_timeout", 32'h0, 32'h1);

    // Reset with two requests outstanding, then a stray response.
    doReset();
    runCycle(0, 0, 32'h0, 1, 0, 32'h0,        1, "seqB");
    runCycle(0, 0, 32'h0, 1, 0, 32'h0,        1, "seqB");
    runCycle(1, 0, 32'h0, 0, 0, 32'h0,        1, "seqB");
    runCycle(0, 0, 32'h0, 0, 1, 32'hBAD0BAD0, 1, "seqB");
    checkOutput("seqB_valid", 32'(bus.valid_out), 32'h0);
    checkOutput("seqB_addr",  bus.inst_addr,      RESET_PC);

    // PC wraps from the top of the address space to zero.
    doReset();
    runCycle(0, 1, 32'hFFFFFFF8, 1, 0, 32'h0, 1, "seqC");
    runCycle(0, 0, 32'h0,        1, 0, 32'h0, 1, "seqC");
    runCycle(0, 0, 32'h0,        1, 0, 32'h0, 1, "seqC");
    checkOutput("seqC_wrap", bus.inst_addr, 32'h0);

    doReset();
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      redir = ($urandom_range(0, 11) == 0);
      rpc   = RESET_PC + (32'($urandom_range(0, 255)) << 2);
      if ($urandom_range(0, 9) == 0) rpc = rpc + 32'($urandom_range(1, 3));
      aok   = ($urandom_range(0, 9) < 7);
      dok   = ($urandom_range(0, 9) < 6);
      allow = ($urandom_range(0, 9) < 7);
      runCycle(rst, redir, rpc, aok, dok, $urandom, allow, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
